// File: rtl/output_buffer.sv
// Byte staging FIFO between packet assembly and serial transmit.
// The head entry is shown first-word-fall-through; the flags are decoded from the registered occupancy.
module output_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 64,
  parameter int READY_LEVEL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_enable,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_enable,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] READY_COUNT = (AW+1)'(READY_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  logic rd_ok;
  logic wr_ok;

  // A write while full still lands when a read frees the head slot in the same cycle.
  assign rd_ok = r_enable && (count != '0);
  assign wr_ok = w_enable && ((count != FULL_COUNT) || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign ready  = (count >= READY_COUNT);
  assign r_data = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_output_buffer.sv
// Randomized and directed bench for output_buffer.
// The reference is a plain queue that models the buffer's occupancy rules.
module tb_output_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int READY_LEVEL = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             w_enable = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r_enable = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             empty;
  logic             full;
  logic             ready;

  int n_checks = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] model_q[$];

  output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READY_LEVEL(READY_LEVEL)) dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WIDTH-1:0] exp_head;
    exp_head = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, " r_data"}, 32'(r_data), 32'(exp_head));
    check({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, " full"}, 32'(full), 32'(model_q.size() == DEPTH));
    check({tag, " ready"}, 32'(ready), 32'(model_q.size() >= READY_LEVEL));
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then check.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re, input string tag);
    bit rd_ok;
    bit wr_ok;
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    @(posedge clk);
    rd_ok = re && (model_q.size() > 0);
    wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    #1;
    check_outputs("post_reset");

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, "fill");
    end
    check("fill full", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0, "overflow");
    check("overflow count", 32'(model_q.size()), 32'(DEPTH));

    for (int i = 0; i < DEPTH; i++) begin
      check("drain order", 32'(r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, "drain");
    end
    check("drain empty", 32'(empty), 32'd1);

    step(1'b1, 8'hFF, 1'b0, "wrap_w0");
    step(1'b1, 8'h00, 1'b0, "wrap_w1");
    check("wrap head", 32'(r_data), 32'hFF);
    step(1'b0, 8'h00, 1'b1, "wrap_r0");
    check("wrap second", 32'(r_data), 32'h00);
    step(1'b0, 8'h00, 1'b1, "wrap_r1");

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, WIDTH'(i + 100), 1'b0, "refill");
    end
    step(1'b1, 8'h55, 1'b1, "simul_full");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, "simul_drain");
    end

    step(1'b1, 8'h12, 1'b1, "simul_empty");
    check("simul_empty head", 32'(r_data), 32'h12);
    step(1'b0, 8'h00, 1'b1, "simul_empty_pop");

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, "underflow");
    end
    step(1'b1, 8'h3C, 1'b0, "after_underflow_w");
    step(1'b0, 8'h00, 1'b1, "after_underflow_r");

    for (int i = 0; i < 5; i++) begin
      step(1'b1, WIDTH'($urandom_range(255)), 1'b0, "pre_reset");
    end
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("after_async_reset");

    for (int i = 0; i < 3000; i++) begin
      int phase;
      int pw;
      int pr;
      phase = (i / 300) % 3;
      pw = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      pr = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      step(($urandom_range(99) < pw), WIDTH'($urandom()), ($urandom_range(99) < pr), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
